// File: rtl/oser4_lane_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : oser4_lane_sched
// Purpose  : Frame scheduler and bring-up sequencer for one OSER4 lane.
//            Presents one 4-bit word per PCLK cycle (low nibble, then high
//            nibble of each byte). Shares the lane between NREQ byte-stream
//            requesters using frame-granular round-robin arbitration. Owns
//            the OSER4 RESET/TX controls and the reset -> train -> run flow.
// Ports    : clk_i        lane PCLK, rising edge
//            nrst_i       synchronous reset, active low
//            req_valid_i  per-requester byte valid
//            req_data_i   per-requester byte, requester i on [8i+7:8i]
//            req_last_i   per-requester last-byte-of-frame flag
//            req_ready_o  per-requester accept (valid & ready on an edge)
//            retrain_i    level request to re-run RST + TRAIN
//            d_o          OSER4 D3..D0 (d_o[0] serialized first)
//            oser_reset_o OSER4 RESET
//            tx_o         OSER4 TX1,TX0 (11 = tristate, 00 = drive)
//            grant_o      one-hot current frame owner, 0 when none
//            link_up_o    high once training has completed
// Revision : 1.0 - initial release
// ============================================================================
module oser4_lane_sched #(
  parameter int          NREQ         = 2,
  parameter int          RST_CYCLES   = 8,
  parameter int          TRAIN_CYCLES = 16,
  parameter logic [3:0]  TRAIN_PAT    = 4'b0101,
  parameter logic [3:0]  IDLE_PAT     = 4'b0000
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic [NREQ-1:0]     req_valid_i,
  input  logic [8*NREQ-1:0]   req_data_i,
  input  logic [NREQ-1:0]     req_last_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic                retrain_i,
  output logic [3:0]          d_o,
  output logic                oser_reset_o,
  output logic [1:0]          tx_o,
  output logic [NREQ-1:0]     grant_o,
  output logic                link_up_o
);

  localparam int IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAXV = (RST_CYCLES > TRAIN_CYCLES) ? RST_CYCLES : TRAIN_CYCLES;
  localparam int CNTW     = $clog2(CNT_MAXV + 1);

  localparam logic [CNTW-1:0] RST_LAST   = CNTW'(RST_CYCLES - 1);
  localparam logic [CNTW-1:0] TRAIN_LAST = CNTW'(TRAIN_CYCLES - 1);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [IDXW-1:0] PTR_INIT   = IDXW'(NREQ - 1);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_TRAIN = 3'd1,
    ST_ARB   = 3'd2,
    ST_FETCH = 3'd3,
    ST_HI    = 3'd4
  } state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [IDXW-1:0]   ptr;       // index of the last requester that finished a frame
  logic [IDXW-1:0]   gidx;      // index of the current owner
  logic [3:0]        hi_nib;
  logic              last_q;

  logic              win_found;
  logic [IDXW-1:0]   win_idx;
  logic [NREQ-1:0]   win_oh;
  logic              sel_valid;
  logic              sel_last;
  logic [7:0]        sel_data;

  // Round-robin search starting just after ptr. The inner loop keeps every
  // bit-select index a loop constant, so no run-time index arithmetic is needed.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && (((int'(ptr) + k) % NREQ) == i) && req_valid_i[i]) begin
          win_found = 1'b1;
          win_idx   = IDXW'(i);
          win_oh[i] = 1'b1;
        end
      end
    end
  end

  // Byte path of the granted requester (grant_o is one-hot or zero).
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = |(req_valid_i & grant_o);
    for (int i = 0; i < NREQ; i++) begin
      if (grant_o[i]) begin
        sel_data = req_data_i[8*i +: 8];
        sel_last = req_last_i[i];
      end
    end
  end

  assign req_ready_o = (state == ST_FETCH) ? grant_o : '0;

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state        <= ST_RST;
      cnt          <= '0;
      d_o          <= IDLE_PAT;
      oser_reset_o <= 1'b1;
      tx_o         <= 2'b11;
      grant_o      <= '0;
      link_up_o    <= 1'b0;
      ptr          <= PTR_INIT;
      gidx         <= '0;
      hi_nib       <= '0;
      last_q       <= 1'b0;
    end else begin
      case (state)
        ST_RST: begin
          if (cnt == RST_LAST) begin
            state        <= ST_TRAIN;
            cnt          <= '0;
            oser_reset_o <= 1'b0;
            tx_o         <= 2'b00;
            d_o          <= TRAIN_PAT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_TRAIN: begin
          if (cnt == TRAIN_LAST) begin
            state     <= ST_ARB;
            cnt       <= '0;
            link_up_o <= 1'b1;
            d_o       <= IDLE_PAT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_ARB: begin
          d_o <= IDLE_PAT;
          // Retrain wins over pending requests; it is only honoured here,
          // so a frame in flight always completes first.
          if (retrain_i) begin
            state        <= ST_RST;
            cnt          <= '0;
            link_up_o    <= 1'b0;
            oser_reset_o <= 1'b1;
            tx_o         <= 2'b11;
          end else if (win_found) begin
            grant_o <= win_oh;
            gidx    <= win_idx;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (sel_valid) begin
            hi_nib <= sel_data[7:4];
            last_q <= sel_last;
            d_o    <= sel_data[3:0];
            state  <= ST_HI;
          end else begin
            // Underrun inside a frame: idle the line but keep the grant.
            d_o <= IDLE_PAT;
          end
        end
        ST_HI: begin
          d_o <= hi_nib;
          if (last_q) begin
            grant_o <= '0;
            ptr     <= gidx;
            state   <= ST_ARB;
          end else begin
            state <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_RST;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
